segre_m_ext_pipeline: RTL and testbench
=======================================

SEGRE_M_EXT_PIPELINE -- requirements
Module: segre_m_ext_pipeline

Interface
Parameters: none; WORD_SIZE, REG_SIZE and m_ext_opcode_e come from segre_pkg.
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk_i input 1 (rising edge); rsn_i input 1 (async, active-low).
REQ-002 valid_m1_i  input  1  M-ext instruction offered by ID.
REQ-003 m1_opcode_i  input  m_ext_opcode_e  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-004 m1_rf_we_i  input  1  destination write request.
REQ-005 m1_rf_waddr_i  input  REG_SIZE  destination register.
REQ-006 m1_rf_src_a_i / m1_rf_src_b_i  input  WORD_SIZE  operands rs1/rs2, already bypassed.
REQ-007 m_busy_o  output  1  offer not accepted this cycle; controller blocks ID.
REQ-008 m5_valid_o, m5_rf_we_o  output  1 each  writeback request from M5.
REQ-009 m5_rf_waddr_o  output  REG_SIZE; m5_rd_data_o  output  WORD_SIZE  writeback address and result; m5_rd_data_o also feeds the M5 bypass.
REQ-010 m_stage_valid_o  output  5  per-stage occupancy, bit 0 = M1, bit 4 = M5.
REQ-011 m_stage_waddr_o  output  5*REG_SIZE  per-stage destination, slice i = stage M(i+1), for hazard detection.

Function
REQ-012 SHALL hold five registered stages M1..M5, each carrying valid, we, waddr, opcode and its datapath state.
REQ-013 An offer SHALL be accepted at a rising edge when valid_m1_i=1 and m_busy_o=0; an offer while m_busy_o=1 SHALL be ignored, with no state change.
REQ-014 The stored we SHALL be m1_rf_we_i AND (m1_rf_waddr_i != 0).
REQ-015 MUL-family ops SHALL advance one stage per edge, with no stall: accepted at edge N, in M1 after N, in M5 after N+4.
REQ-016 MUL-family results SHALL be:
- MUL: low 32 bits of the product.
- MULH: high 32 bits, both operands signed.
- MULHSU: high 32 bits, a signed, b unsigned.
- MULHU: high 32 bits, both unsigned.
- Method: 33x33-bit signed product of sign/zero-extended operands; partial-product split across M2..M4 is free, but every inter-stage value is registered.
REQ-017 A DIV-family op SHALL hold in M1 while a radix-2 restoring divider runs exactly 32 iterations.
- Iteration counter: 0 after acceptance, +1 per edge.
- The op leaves M1 at the edge where the counter is 31.
- Accepted at edge N: in M2 after N+32, in M5 after N+35.
REQ-018 m_busy_o SHALL be combinational: 1 when M1 holds a DIV-family op with counter < 31, else 0.
- It is asserted for exactly 31 cycles per divide.
- A new op may be accepted on the same edge the divide leaves M1.
REQ-019 While M1 is stalled, M2..M5 SHALL keep advancing and a bubble (valid=0) SHALL enter M2 each edge.
REQ-020 Signed DIV/REM SHALL divide magnitudes.
- Quotient is negated when operand signs differ.
- Remainder takes the dividend's sign.
REQ-021 Divisor zero SHALL give: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU result = dividend. Latency stays 32 iterations.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and REM 0. Latency unchanged.
REQ-023 m5_* outputs SHALL be driven combinationally from the M5 register.
- m5_valid_o is high for exactly one cycle per op.
- When M5 valid=0: m5_rf_we_o = 0 and m5_rd_data_o = 0.
REQ-024 m_stage_valid_o and m_stage_waddr_o SHALL reflect the current stage registers; stalled M1 reports valid=1.

Reset
REQ-025 rsn_i=0 SHALL immediately clear all stage valid, we and waddr bits, the divider state and the counter; an in-flight op is discarded.
REQ-026 During reset, every output SHALL be 0: m_busy_o, m5_valid_o, m5_rf_we_o, m5_rf_waddr_o, m5_rd_data_o, m_stage_valid_o, m_stage_waddr_o.
REQ-027 After release, the first rising edge SHALL accept an offer.

Verification
REQ-028 MUL 7 x 0xFFFFFFFD, waddr 5, accepted edge N -> between N+4 and N+5: m5_valid_o=1, waddr 5, data 0xFFFFFFEB; m5_valid_o=0 afterwards.
REQ-029 Operands 0xFFFFFFFF x 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF, MUL 0x00000001.
REQ-030 Five MULs on consecutive edges with waddr=0, one with waddr=3 -> five consecutive m5_valid_o cycles, in order; m5_rf_we_o=0 for waddr 0.
REQ-031 DIV 0xFFFFFF9C / 7 accepted edge N; MUL issued at N-1 -> MUL writes back normally; m_busy_o high 31 cycles; quotient 0xFFFFFFF2 in M5 between N+35 and N+36; REM of same operands gives 0xFFFFFFFE.
REQ-032 Corner divides -> DIVU 5/0 = 0xFFFFFFFF; REMU 5/0 = 5; DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM of same = 0.
REQ-033 rsn_i pulsed low at iteration 10 of a DIV -> all outputs 0 immediately, no writeback; a MUL after release completes with 5-cycle latency.

Source files
------------

// File: rtl/segre_m_ext_pipeline.sv
// ============================================================================
// segre_m_ext_pipeline : five-stage RV32M multiply / divide pipeline (M1..M5)
// Revision 1.0
// ============================================================================
`default_nettype none

package segre_pkg;
   localparam int WORD_SIZE = 32;
   localparam int REG_SIZE  = 5;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } m_ext_opcode_e;
endpackage

module segre_m_ext_pipeline
   import segre_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rsn_i,
   input  logic                   valid_m1_i,
   input  m_ext_opcode_e          m1_opcode_i,
   input  logic                   m1_rf_we_i,
   input  logic [REG_SIZE-1:0]    m1_rf_waddr_i,
   input  logic [WORD_SIZE-1:0]   m1_rf_src_a_i,
   input  logic [WORD_SIZE-1:0]   m1_rf_src_b_i,
   output logic                   m_busy_o,
   output logic                   m5_valid_o,
   output logic                   m5_rf_we_o,
   output logic [REG_SIZE-1:0]    m5_rf_waddr_o,
   output logic [WORD_SIZE-1:0]   m5_rd_data_o,
   output logic [4:0]             m_stage_valid_o,
   output logic [5*REG_SIZE-1:0]  m_stage_waddr_o
);

   localparam int         NUM_STAGES = 5;
   localparam int         DW         = 2 * WORD_SIZE;
   localparam int         SPLIT      = 17;
   localparam logic [4:0] LAST_ITER  = 5'd31;

   function automatic logic is_div_op(input m_ext_opcode_e op);
      return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
   endfunction

   function automatic logic is_low_word(input m_ext_opcode_e op);
      return (op != MULH) && (op != MULHSU) && (op != MULHU);
   endfunction

   // Stage control state
   logic [NUM_STAGES-1:0]               st_valid;
   logic [NUM_STAGES-1:0]               st_we;
   logic [NUM_STAGES-1:0][REG_SIZE-1:0] st_waddr;
   m_ext_opcode_e                       st_op [NUM_STAGES];

   // Datapath state
   logic [WORD_SIZE-1:0] m1_a;
   logic [WORD_SIZE-1:0] m1_b;
   logic [WORD_SIZE-1:0] div_rem;
   logic [WORD_SIZE-1:0] div_quo;
   logic [WORD_SIZE-1:0] div_dvsr;
   logic [4:0]           div_cnt;
   logic                 div_neg_q;
   logic                 div_neg_r;
   logic                 div_zero;
   logic [DW-1:0]        m2_pp_lo;
   logic [DW-1:0]        m2_pp_hi;
   logic [DW-1:0]        m3_prod;
   logic [WORD_SIZE-1:0] m4_res;
   logic [WORD_SIZE-1:0] m5_res;

   logic m1_is_div;
   logic m1_stall;
   logic accept;

   assign m1_is_div = st_valid[0] && is_div_op(st_op[0]);
   assign m1_stall  = m1_is_div && (div_cnt != LAST_ITER);
   assign accept    = valid_m1_i && !m1_stall;
   assign m_busy_o  = m1_stall;

   // Operand sign handling at acceptance
   logic in_a_neg;
   logic in_b_neg;

   always_comb begin
      in_a_neg = ((m1_opcode_i == DIV) || (m1_opcode_i == REM)) && m1_rf_src_a_i[WORD_SIZE-1];
      in_b_neg = ((m1_opcode_i == DIV) || (m1_opcode_i == REM)) && m1_rf_src_b_i[WORD_SIZE-1];
   end

   // One restoring-division step; the last step feeds M2 directly
   logic [WORD_SIZE:0]   rem_shift;
   logic [WORD_SIZE:0]   rem_trial;
   logic [WORD_SIZE-1:0] quo_next;
   logic [WORD_SIZE-1:0] rem_next;
   logic [WORD_SIZE-1:0] div_q;
   logic [WORD_SIZE-1:0] div_r;
   logic [WORD_SIZE-1:0] div_res;

   always_comb begin
      rem_shift = {div_rem, div_quo[WORD_SIZE-1]};
      rem_trial = rem_shift - {1'b0, div_dvsr};
      if (rem_trial[WORD_SIZE]) begin
         rem_next = rem_shift[WORD_SIZE-1:0];
         quo_next = {div_quo[WORD_SIZE-2:0], 1'b0};
      end else begin
         rem_next = rem_trial[WORD_SIZE-1:0];
         quo_next = {div_quo[WORD_SIZE-2:0], 1'b1};
      end
      div_q   = div_zero ? '1 : (div_neg_q ? -quo_next : quo_next);
      div_r   = div_neg_r ? -rem_next : rem_next;
      div_res = ((st_op[0] == DIV) || (st_op[0] == DIVU)) ? div_q : div_r;
   end

   // 33x33 signed product, taken modulo 2^64, split on bit SPLIT of b
   logic          mul_a_signed;
   logic          mul_b_signed;
   logic [DW-1:0] a_ext;
   logic [DW-1:0] b_ext;
   logic [DW-1:0] pp_lo_c;
   logic [DW-1:0] pp_hi_c;

   always_comb begin
      mul_a_signed = (st_op[0] == MULH) || (st_op[0] == MULHSU);
      mul_b_signed = (st_op[0] == MULH);
      a_ext   = {{WORD_SIZE{mul_a_signed & m1_a[WORD_SIZE-1]}}, m1_a};
      b_ext   = {{WORD_SIZE{mul_b_signed & m1_b[WORD_SIZE-1]}}, m1_b};
      pp_lo_c = a_ext * {{(DW-SPLIT){1'b0}}, b_ext[SPLIT-1:0]};
      pp_hi_c = a_ext * {{SPLIT{1'b0}}, b_ext[DW-1:SPLIT]};
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         st_valid <= '0;
         st_we    <= '0;
         st_waddr <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            st_op[i] <= MUL;
         end
      end else begin
         if (accept) begin
            st_valid[0] <= 1'b1;
            st_we[0]    <= m1_rf_we_i && (m1_rf_waddr_i != '0);
            st_waddr[0] <= m1_rf_waddr_i;
            st_op[0]    <= m1_opcode_i;
         end else if (!m1_stall) begin
            st_valid[0] <= 1'b0;
            st_we[0]    <= 1'b0;
         end
         // A stalled M1 sends a bubble into M2
         st_valid[1] <= st_valid[0] && !m1_stall;
         st_we[1]    <= st_we[0] && !m1_stall;
         st_waddr[1] <= st_waddr[0];
         st_op[1]    <= st_op[0];
         for (int i = 2; i < NUM_STAGES; i++) begin
            st_valid[i] <= st_valid[i-1];
            st_we[i]    <= st_we[i-1];
            st_waddr[i] <= st_waddr[i-1];
            st_op[i]    <= st_op[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         m1_a      <= '0;
         m1_b      <= '0;
         div_rem   <= '0;
         div_quo   <= '0;
         div_dvsr  <= '0;
         div_cnt   <= '0;
         div_neg_q <= 1'b0;
         div_neg_r <= 1'b0;
         div_zero  <= 1'b0;
      end else if (accept) begin
         m1_a      <= m1_rf_src_a_i;
         m1_b      <= m1_rf_src_b_i;
         div_rem   <= '0;
         div_quo   <= in_a_neg ? -m1_rf_src_a_i : m1_rf_src_a_i;
         div_dvsr  <= in_b_neg ? -m1_rf_src_b_i : m1_rf_src_b_i;
         div_cnt   <= '0;
         div_neg_q <= in_a_neg ^ in_b_neg;
         div_neg_r <= in_a_neg;
         div_zero  <= (m1_rf_src_b_i == '0);
      end else if (m1_is_div) begin
         div_rem <= rem_next;
         div_quo <= quo_next;
         div_cnt <= div_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         m2_pp_lo <= '0;
         m2_pp_hi <= '0;
         m3_prod  <= '0;
         m4_res   <= '0;
         m5_res   <= '0;
      end else begin
         if (m1_is_div) begin
            m2_pp_lo <= {{WORD_SIZE{1'b0}}, div_res};
            m2_pp_hi <= '0;
         end else begin
            m2_pp_lo <= pp_lo_c;
            m2_pp_hi <= pp_hi_c;
         end
         m3_prod <= m2_pp_lo + (m2_pp_hi << SPLIT);
         m4_res  <= is_low_word(st_op[2]) ? m3_prod[WORD_SIZE-1:0] : m3_prod[DW-1:WORD_SIZE];
         m5_res  <= m4_res;
      end
   end

   assign m5_valid_o      = st_valid[4];
   assign m5_rf_we_o      = st_valid[4] && st_we[4];
   assign m5_rf_waddr_o   = st_waddr[4];
   assign m5_rd_data_o    = st_valid[4] ? m5_res : '0;
   assign m_stage_valid_o = st_valid;
   assign m_stage_waddr_o = st_waddr;

endmodule

`default_nettype wire

// File: tb/tb_segre_m_ext_pipeline.sv
// ============================================================================
// tb_segre_m_ext_pipeline : directed scoreboard bench for the M-ext pipeline
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_segre_m_ext_pipeline;
   import segre_pkg::*;

   logic                  clk = 1'b0;
   logic                  rsn_i;
   logic                  valid_m1_i;
   m_ext_opcode_e         m1_opcode_i;
   logic                  m1_rf_we_i;
   logic [REG_SIZE-1:0]   m1_rf_waddr_i;
   logic [WORD_SIZE-1:0]  m1_rf_src_a_i;
   logic [WORD_SIZE-1:0]  m1_rf_src_b_i;
   logic                  m_busy_o;
   logic                  m5_valid_o;
   logic                  m5_rf_we_o;
   logic [REG_SIZE-1:0]   m5_rf_waddr_o;
   logic [WORD_SIZE-1:0]  m5_rd_data_o;
   logic [4:0]            m_stage_valid_o;
   logic [5*REG_SIZE-1:0] m_stage_waddr_o;

   always #5 clk = ~clk;

   segre_m_ext_pipeline dut (
      .clk_i           (clk),
      .rsn_i           (rsn_i),
      .valid_m1_i      (valid_m1_i),
      .m1_opcode_i     (m1_opcode_i),
      .m1_rf_we_i      (m1_rf_we_i),
      .m1_rf_waddr_i   (m1_rf_waddr_i),
      .m1_rf_src_a_i   (m1_rf_src_a_i),
      .m1_rf_src_b_i   (m1_rf_src_b_i),
      .m_busy_o        (m_busy_o),
      .m5_valid_o      (m5_valid_o),
      .m5_rf_we_o      (m5_rf_we_o),
      .m5_rf_waddr_o   (m5_rf_waddr_o),
      .m5_rd_data_o    (m5_rd_data_o),
      .m_stage_valid_o (m_stage_valid_o),
      .m_stage_waddr_o (m_stage_waddr_o)
   );

   typedef struct {
      logic [4:0]  waddr;
      logic        we;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t scb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input m_ext_opcode_e op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa;
      longint      sbv;
      longint      p;
      logic [63:0] up;
      logic [31:0] r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      up  = {32'b0, a} * {32'b0, b};
      r   = '0;
      case (op)
         MUL:    r = up[31:0];
         MULH:   begin p = sa * sbv; r = p[63:32]; end
         MULHSU: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
         MULHU:  r = up[63:32];
         DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                     (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sbv);
         DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:    r = (b == 0) ? a :
                     (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sbv);
         REMU:   r = (b == 0) ? a : a % b;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic monitor();
      exp_t e;
      if (m5_valid_o) begin
         if (scb.size() == 0) begin
            check("unexpected_wb", m5_valid_o, 0);
         end else begin
            e = scb.pop_front();
            check("wb_cycle", cycle, e.due);
            check("wb_waddr", m5_rf_waddr_o, e.waddr);
            check("wb_we", m5_rf_we_o, e.we);
            check("wb_data", m5_rd_data_o, e.data);
         end
      end else begin
         check("idle_we", m5_rf_we_o, 0);
         check("idle_data", m5_rd_data_o, 0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cycle++;
      monitor();
   endtask

   task automatic issue(input m_ext_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic we, input logic [31:0] exp);
      exp_t e;
      check("offer_busy", m_busy_o, 0);
      valid_m1_i    = 1'b1;
      m1_opcode_i   = op;
      m1_rf_src_a_i = a;
      m1_rf_src_b_i = b;
      m1_rf_waddr_i = wa;
      m1_rf_we_i    = we;
      step();
      valid_m1_i = 1'b0;
      e.waddr = wa;
      e.we    = we && (wa != 0);
      e.data  = exp;
      e.due   = cycle + ((op inside {DIV, DIVU, REM, REMU}) ? 35 : 4);
      scb.push_back(e);
   endtask

   task automatic wait_ready();
      int g = 0;
      while (m_busy_o && g < 50) begin
         step();
         g++;
      end
   endtask

   task automatic drain();
      int g = 0;
      while (scb.size() > 0 && g < 100) begin
         step();
         g++;
      end
      check("drain_empty", scb.size(), 0);
      step();
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, m_busy_o, 0);
      check({tag, "_m5_valid"}, m5_valid_o, 0);
      check({tag, "_m5_we"}, m5_rf_we_o, 0);
      check({tag, "_m5_waddr"}, m5_rf_waddr_o, 0);
      check({tag, "_m5_data"}, m5_rd_data_o, 0);
      check({tag, "_stage_valid"}, m_stage_valid_o, 0);
      check({tag, "_stage_waddr"}, m_stage_waddr_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]   ra;
      logic [31:0]   rb;
      m_ext_opcode_e rop;
      int            busy_n;
      int            g;

      rsn_i         = 1'b0;
      valid_m1_i    = 1'b0;
      m1_opcode_i   = MUL;
      m1_rf_we_i    = 1'b0;
      m1_rf_waddr_i = '0;
      m1_rf_src_a_i = '0;
      m1_rf_src_b_i = '0;
      #2;
      check_all_zero("reset");
      step();
      step();
      rsn_i = 1'b1;

      // Basic MUL, accepted on the first edge after release
      issue(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB);
      check("m1_occupied", m_stage_valid_o, 5'b00001);
      check("m1_waddr", m_stage_waddr_o[4:0], 5);
      drain();

      // Signedness of the high-word products
      issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'hFFFF_FFFE);
      issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'h0000_0000);
      issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'hFFFF_FFFF);
      issue(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'h0000_0001);
      drain();

      // Back-to-back with x0 destinations
      issue(MUL, 32'd3,  32'd5,  5'd0, 1'b1, 32'd15);
      issue(MUL, 32'd4,  32'd6,  5'd0, 1'b1, 32'd24);
      issue(MUL, 32'd10, 32'd11, 5'd3, 1'b1, 32'd110);
      issue(MUL, 32'd12, 32'd12, 5'd0, 1'b1, 32'd144);
      issue(MUL, 32'd9,  32'd9,  5'd0, 1'b1, 32'd81);
      drain();

      // Random MUL-family stream
      for (int i = 0; i < 8; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = m_ext_opcode_e'(3'($urandom_range(0, 3)));
         issue(rop, ra, rb, 5'(i + 1), 1'b1, model(rop, ra, rb));
      end
      drain();

      // Divide stalls M1 while an older MUL drains; offers during busy are dropped
      issue(MUL, 32'd3, 32'd4, 5'd6, 1'b1, 32'd12);
      issue(DIV, 32'hFFFF_FF9C, 32'd7, 5'd7, 1'b1, 32'hFFFF_FFF2);
      check("div_accept_stages", m_stage_valid_o, 5'b00011);
      valid_m1_i    = 1'b1;
      m1_opcode_i   = MUL;
      m1_rf_src_a_i = 32'd1;
      m1_rf_src_b_i = 32'd1;
      m1_rf_waddr_i = 5'd9;
      m1_rf_we_i    = 1'b1;
      busy_n = 0;
      g      = 0;
      while (m_busy_o && g < 40) begin
         busy_n++;
         if (busy_n == 10) begin
            check("stall_m1_valid", m_stage_valid_o[0], 1);
            check("stall_m1_waddr", m_stage_waddr_o[4:0], 7);
            check("stall_m2_bubble", m_stage_valid_o[1], 0);
         end
         step();
         g++;
      end
      valid_m1_i = 1'b0;
      check("busy_cycles", busy_n, 31);
      issue(REM, 32'hFFFF_FF9C, 32'd7, 5'd8, 1'b1, 32'hFFFF_FFFE);
      drain();

      // Divide corner cases and a few signed mixes
      issue(DIVU, 32'd5, 32'd0, 5'd1, 1'b1, 32'hFFFF_FFFF);
      wait_ready();
      issue(REMU, 32'd5, 32'd0, 5'd2, 1'b1, 32'd5);
      wait_ready();
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h8000_0000);
      wait_ready();
      issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'h0000_0000);
      wait_ready();
      issue(DIV, 32'hFFFF_FFF9, 32'd0, 5'd5, 1'b1, 32'hFFFF_FFFF);
      wait_ready();
      issue(REM, 32'd7, 32'hFFFF_FFFD, 5'd6, 1'b1, 32'd1);
      wait_ready();
      issue(DIV, 32'd7, 32'hFFFF_FFFD, 5'd7, 1'b1, 32'hFFFF_FFFE);
      wait_ready();
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      issue(DIVU, ra, rb, 5'd8, 1'b1, model(DIVU, ra, rb));
      wait_ready();
      issue(REM, ra, rb, 5'd9, 1'b1, model(REM, ra, rb));
      drain();

      // Reset in the middle of a divide discards it
      issue(DIV, 32'd100, 32'd7, 5'd10, 1'b1, 32'd14);
      for (int i = 0; i < 10; i++) begin
         step();
      end
      #2;
      rsn_i = 1'b0;
      #1;
      check_all_zero("mid_reset");
      scb.delete();
      step();
      step();
      rsn_i = 1'b1;
      issue(MUL, 32'd6, 32'd7, 5'd11, 1'b1, 32'd42);
      drain();
      for (int i = 0; i < 40; i++) begin
         step();
      end
      check("final_empty", scb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
